// File: rtl/vending_pkg.sv
// vending_pkg: coin codes, FSM state type and coin value decode shared by the vending machine
package vending_pkg;
  localparam int PKG_CREDIT_W = 8;
  localparam logic [1:0] COIN_NONE = 2'd0;
  localparam logic [1:0] COIN_1 = 2'd1;
  localparam logic [1:0] COIN_2 = 2'd2;
  localparam logic [1:0] COIN_3 = 2'd3;
  typedef enum logic [1:0] {S_IDLE, S_CREDIT, S_VEND, S_CHANGE} state_t;
  function automatic logic [PKG_CREDIT_W-1:0] coin_value(input logic [1:0] code, input int v1, input int v2, input int v3);
    return code == COIN_1 ? PKG_CREDIT_W'(v1) :
           code == COIN_2 ? PKG_CREDIT_W'(v2) :
           code == COIN_3 ? PKG_CREDIT_W'(v3) : '0;
  endfunction
endpackage

// File: rtl/vending_machine_multi_change_dispenser.sv
// change_dispenser: loads an amount and pays it out greedily, one registered coin per cycle
module change_dispenser
  import vending_pkg::*;
#(
  parameter int CREDIT_W = 8,
  parameter int V1 = 5,
  parameter int V2 = 10,
  parameter int V3 = 25
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [CREDIT_W-1:0] amount,
  output logic [1:0]          change,
  output logic                change_valid,
  output logic                done,
  output logic [CREDIT_W-1:0] rem_next
);
  logic [CREDIT_W-1:0] rem_q, rem_d, amt, val;
  logic [1:0] change_q, change_d;
  logic valid_q, valid_d;
  // The first coin leaves on the load edge itself, so it is visible the cycle after the request.
  always_comb begin
    amt = load ? amount : rem_q;
    change_d = amt >= CREDIT_W'(V3) ? COIN_3 :
               amt >= CREDIT_W'(V2) ? COIN_2 :
               amt >= CREDIT_W'(V1) ? COIN_1 : COIN_NONE;
    val = CREDIT_W'(coin_value(change_d, V1, V2, V3));
    rem_d = amt - val;
    valid_d = change_d != COIN_NONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      change_q <= COIN_NONE;
      valid_q <= 1'b0;
    end else begin
      rem_q <= rem_d;
      change_q <= change_d;
      valid_q <= valid_d;
    end
  end
  assign change = change_q;
  assign change_valid = valid_q;
  assign done = rem_q == '0;
  assign rem_next = rem_d;
endmodule

// File: rtl/vending_machine_multi.sv
// vending_machine_multi: multi-item coin vending FSM with stock, refund, restock and serial change
module vending_machine_multi
  import vending_pkg::*;
#(
  parameter int NUM_ITEMS = 4,
  parameter int SEL_W = 2,
  parameter int CREDIT_W = 8,
  parameter int COIN1_VAL = 5,
  parameter int COIN2_VAL = 10,
  parameter int COIN3_VAL = 25,
  parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES = {8'd30, 8'd25, 8'd20, 8'd15},
  parameter int MAX_CREDIT = 100,
  parameter int STOCK_W = 4,
  parameter int STOCK_INIT = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          coin,
  input  logic                sel_valid,
  input  logic [SEL_W-1:0]    sel,
  input  logic                cancel,
  input  logic                restock,
  output logic                out,
  output logic [SEL_W-1:0]    item,
  output logic [1:0]          change,
  output logic                change_valid,
  output logic                coin_reject,
  output logic                sold_out,
  output logic                insufficient,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);
  state_t state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d, coin_val, price, disp_rem;
  logic [CREDIT_W:0] sum;
  logic [STOCK_W-1:0] stock_q [NUM_ITEMS];
  logic [STOCK_W-1:0] stock_d [NUM_ITEMS];
  logic [SEL_W-1:0] item_q, item_d;
  logic out_q, out_d, rej_q, rej_d, sold_q, sold_d, insuf_q, insuf_d, busy_q, busy_d;
  logic load, disp_done, sel_ok, has_coin;
  change_dispenser #(
    .CREDIT_W(CREDIT_W), .V1(COIN1_VAL), .V2(COIN2_VAL), .V3(COIN3_VAL)
  ) u_disp (
    .clk(clk), .rst(rst), .load(load), .amount(credit_q),
    .change(change), .change_valid(change_valid), .done(disp_done), .rem_next(disp_rem)
  );
  always_comb begin
    coin_val = CREDIT_W'(coin_value(coin, COIN1_VAL, COIN2_VAL, COIN3_VAL));
    price = PRICES[int'(sel)*CREDIT_W +: CREDIT_W];
    sum = {1'b0, credit_q} + {1'b0, coin_val};
    sel_ok = int'(sel) < NUM_ITEMS;
    has_coin = coin != COIN_NONE;
    state_d = state_q;
    credit_d = credit_q;
    item_d = item_q;
    stock_d = stock_q;
    out_d = 1'b0;
    rej_d = 1'b0;
    sold_d = 1'b0;
    insuf_d = 1'b0;
    load = 1'b0;
    if (state_q == S_VEND || state_q == S_CHANGE) begin
      rej_d = has_coin;
      load = state_q == S_VEND && credit_q != '0;
      state_d = state_q == S_VEND ? (load ? S_CHANGE : S_IDLE) : (disp_done ? S_IDLE : S_CHANGE);
      credit_d = disp_rem;
    end else if (cancel) begin
      rej_d = has_coin;
      load = credit_q != '0;
      state_d = load ? S_CHANGE : state_q;
      credit_d = load ? disp_rem : credit_q;
    end else if (sel_valid) begin
      rej_d = has_coin;
      if (sel_ok) begin
        if (stock_q[sel] == '0) sold_d = 1'b1;
        else if (credit_q < price) insuf_d = 1'b1;
        else begin
          state_d = S_VEND;
          out_d = 1'b1;
          item_d = sel;
          stock_d[sel] = stock_q[sel] - 1'b1;
          credit_d = credit_q - price;
        end
      end
    end else if (has_coin) begin
      // Guard bit in sum keeps the ceiling compare honest near the top of the credit range.
      rej_d = sum > (CREDIT_W+1)'(MAX_CREDIT);
      credit_d = rej_d ? credit_q : sum[CREDIT_W-1:0];
      state_d = rej_d ? state_q : S_CREDIT;
    end
    if (restock) for (int i = 0; i < NUM_ITEMS; i++) stock_d[i] = STOCK_W'(STOCK_INIT);
    busy_d = state_d == S_VEND || state_d == S_CHANGE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      credit_q <= '0;
      item_q <= '0;
      out_q <= 1'b0;
      rej_q <= 1'b0;
      sold_q <= 1'b0;
      insuf_q <= 1'b0;
      busy_q <= 1'b0;
      for (int i = 0; i < NUM_ITEMS; i++) stock_q[i] <= STOCK_W'(STOCK_INIT);
    end else begin
      state_q <= state_d;
      credit_q <= credit_d;
      item_q <= item_d;
      out_q <= out_d;
      rej_q <= rej_d;
      sold_q <= sold_d;
      insuf_q <= insuf_d;
      busy_q <= busy_d;
      stock_q <= stock_d;
    end
  end
  assign out = out_q;
  assign item = item_q;
  assign coin_reject = rej_q;
  assign sold_out = sold_q;
  assign insufficient = insuf_q;
  assign credit = credit_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_vending_machine_multi.sv
// tb_vending_machine_multi: directed steps with an event scoreboard for pulses and change coins
module tb_vending_machine_multi;
  logic clk = 1'b0, rst = 1'b1;
  logic [1:0] coin = '0, sel = '0;
  logic sel_valid = 1'b0, cancel = 1'b0, restock = 1'b0;
  logic out, change_valid, coin_reject, sold_out, insufficient, busy;
  logic [1:0] item, change;
  logic [7:0] credit;
  int n_vec = 0, n_err = 0, b;
  typedef struct packed {logic [2:0] k; logic [1:0] v;} ev_t;
  ev_t exp_q[$];
  localparam logic [2:0] K_VEND = 3'd0, K_CHG = 3'd1, K_REJ = 3'd2, K_SOLD = 3'd3, K_INS = 3'd4;

  vending_machine_multi dut (
    .clk(clk), .rst(rst), .coin(coin), .sel_valid(sel_valid), .sel(sel), .cancel(cancel),
    .restock(restock), .out(out), .item(item), .change(change), .change_valid(change_valid),
    .coin_reject(coin_reject), .sold_out(sold_out), .insufficient(insufficient),
    .credit(credit), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [2:0] k, input logic [1:0] v);
    exp_q.push_back({k, v});
  endtask

  task automatic seen(input logic [2:0] k, input logic [1:0] v, input string tag);
    ev_t e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $error("FAIL %s: observed event val %0d expected no event", tag, v);
    end else begin
      e = exp_q.pop_front();
      assert (e.k === k && e.v === v) else begin
        n_err++;
        $error("FAIL %s: observed kind %0d val %0d expected kind %0d val %0d", tag, k, v, e.k, e.v);
      end
    end
  endtask

  always @(negedge clk) begin
    if (out) seen(K_VEND, item, "vend");
    if (change_valid) seen(K_CHG, change, "change");
    if (coin_reject) seen(K_REJ, 2'd0, "coin_reject");
    if (sold_out) seen(K_SOLD, 2'd0, "sold_out");
    if (insufficient) seen(K_INS, 2'd0, "insufficient");
  end

  task automatic cyc(input logic [1:0] c, input logic sv, input logic [1:0] s, input logic cn, input logic rs);
    coin = c; sel_valid = sv; sel = s; cancel = cn; restock = rs;
    @(posedge clk);
    #1;
    coin = '0; sel_valid = 1'b0; cancel = 1'b0; restock = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) cyc(2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
  endtask
  task automatic ins(input logic [1:0] c);
    cyc(c, 1'b0, 2'd0, 1'b0, 1'b0);
  endtask
  task automatic pick(input logic [1:0] s);
    cyc(2'd0, 1'b1, s, 1'b0, 1'b0);
  endtask
  task automatic refund();
    cyc(2'd0, 1'b0, 2'd0, 1'b1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of run, expected $finish");
    $fatal(1);
  end

  initial begin
    idle(2);
    chk("rst_credit", credit, 0);
    chk("rst_out", out, 0);
    chk("rst_change_valid", change_valid, 0);
    chk("rst_change", change, 0);
    chk("rst_item", item, 0);
    chk("rst_busy", busy, 0);
    chk("rst_reject", coin_reject, 0);
    rst = 1'b0;
    // 10+10, item 0 at 15, one coin of 5 back
    ins(2'd2); ins(2'd2);
    chk("t1_credit20", credit, 20);
    push(K_VEND, 2'd0); push(K_CHG, 2'd1);
    pick(2'd0);
    chk("t1_out", out, 1);
    chk("t1_busy_vend", busy, 1);
    chk("t1_credit_after_price", credit, 5);
    idle(1);
    chk("t1_cv", change_valid, 1);
    chk("t1_change", change, 1);
    chk("t1_credit0", credit, 0);
    chk("t1_out_off", out, 0);
    idle(1);
    chk("t1_idle_busy", busy, 0);
    chk("t1_cv_off", change_valid, 0);
    // 25, item 1 at 20: busy for VEND plus one CHANGE cycle
    ins(2'd3);
    push(K_VEND, 2'd1); push(K_CHG, 2'd1);
    pick(2'd1);
    b = int'(busy);
    repeat (4) begin idle(1); b += int'(busy); end
    chk("t2_busy_cycles", b, 2);
    // cancel with 35
    ins(2'd3); ins(2'd2);
    chk("t3_credit35", credit, 35);
    push(K_CHG, 2'd3); push(K_CHG, 2'd2);
    refund();
    chk("t3_no_out", out, 0);
    chk("t3_cv1", change_valid, 1);
    chk("t3_code3", change, 3);
    chk("t3_credit10", credit, 10);
    idle(1);
    chk("t3_code2", change, 2);
    chk("t3_credit0", credit, 0);
    idle(1);
    chk("t3_busy_off", busy, 0);
    // credit ceiling, then item 3 with a coin inserted mid-change
    repeat (4) ins(2'd3);
    chk("t4_credit100", credit, 100);
    push(K_REJ, 2'd0);
    ins(2'd3);
    chk("t4_reject", coin_reject, 1);
    chk("t4_credit_held", credit, 100);
    idle(1);
    chk("t4_reject_pulse", coin_reject, 0);
    push(K_VEND, 2'd3); push(K_CHG, 2'd3); push(K_CHG, 2'd3); push(K_REJ, 2'd0);
    push(K_CHG, 2'd2); push(K_CHG, 2'd2);
    pick(2'd3);
    chk("t4_credit70", credit, 70);
    idle(1);
    ins(2'd1);
    chk("t4_reject_in_change", coin_reject, 1);
    chk("t4_credit20", credit, 20);
    idle(4);
    chk("t4_credit0", credit, 0);
    chk("t4_busy_off", busy, 0);
    // insufficient credit, with a coin clashing with the selection
    ins(2'd1);
    push(K_REJ, 2'd0); push(K_INS, 2'd0);
    cyc(2'd2, 1'b1, 2'd2, 1'b0, 1'b0);
    chk("ins_pulse", insufficient, 1);
    chk("ins_credit_kept", credit, 5);
    push(K_CHG, 2'd1);
    refund();
    idle(2);
    chk("ins_refunded", credit, 0);
    // drain item 0 (one left), then sold out, restock, vend
    ins(2'd2); ins(2'd1);
    push(K_VEND, 2'd0);
    pick(2'd0);
    chk("t5_exact_credit", credit, 0);
    idle(2);
    chk("t5_exact_idle", busy, 0);
    ins(2'd3);
    push(K_SOLD, 2'd0);
    pick(2'd0);
    chk("t5_sold_out", sold_out, 1);
    chk("t5_credit_kept", credit, 25);
    cyc(2'd0, 1'b0, 2'd0, 1'b0, 1'b1);
    push(K_VEND, 2'd0); push(K_CHG, 2'd2);
    pick(2'd0);
    chk("t5_restocked_out", out, 1);
    idle(3);
    chk("t5_credit0", credit, 0);
    // reset during the first change cycle
    ins(2'd3); ins(2'd2);
    push(K_VEND, 2'd3); push(K_CHG, 2'd1);
    pick(2'd3);
    idle(1);
    chk("t6_cv", change_valid, 1);
    chk("t6_busy", busy, 1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("t6_credit", credit, 0);
    chk("t6_cv_off", change_valid, 0);
    chk("t6_busy_off", busy, 0);
    chk("t6_item", item, 0);
    // reset restored item 3 to two units
    repeat (2) begin
      ins(2'd3); ins(2'd1);
      push(K_VEND, 2'd3);
      pick(2'd3);
      idle(2);
    end
    ins(2'd3); ins(2'd1);
    push(K_SOLD, 2'd0);
    pick(2'd3);
    chk("t6_third_sold_out", sold_out, 1);
    push(K_CHG, 2'd3); push(K_CHG, 2'd1);
    refund();
    idle(3);
    chk("t6_credit0", credit, 0);
    // reset drops the rest of a refund in flight
    ins(2'd3); ins(2'd2);
    push(K_CHG, 2'd3);
    refund();
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(3);
    chk("t7_credit", credit, 0);
    chk("t7_cv_off", change_valid, 0);
    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
